// File: rtl/cpu_game_pkg.sv
// rtl/cpu_game_pkg.sv - shared attack-type, FSM-state and damage constants for the CPU opponent
package cpu_game_pkg;

    // Attack types, shared with the CPU clock generator
    localparam logic [1:0] STANDBY = 2'b00;
    localparam logic [1:0] LIGHT   = 2'b01;
    localparam logic [1:0] HEAVY   = 2'b10;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_WINDUP  = 2'b01;
    localparam logic [1:0] ST_STRIKE  = 2'b10;
    localparam logic [1:0] ST_RECOVER = 2'b11;

    localparam logic [1:0] LIGHT_DMG = 2'd1;
    localparam logic [1:0] HEAVY_DMG = 2'd3;

    // Two LFSR bits map to a weighted draw: one STANDBY, two LIGHT, one HEAVY
    function automatic logic [1:0] draw_type(input logic [1:0] bits);
        logic [1:0] t;
        case (bits)
            2'b00:   t = STANDBY;
            2'b01:   t = LIGHT;
            2'b10:   t = LIGHT;
            default: t = HEAVY;
        endcase
        return t;
    endfunction

    function automatic logic [1:0] damage_of(input logic [1:0] attack_type);
        logic [1:0] d;
        case (attack_type)
            LIGHT:   d = LIGHT_DMG;
            HEAVY:   d = HEAVY_DMG;
            default: d = 2'd0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/lfsr4_xnor.sv
// rtl/lfsr4_xnor.sv - 4-bit XNOR LFSR, free-running out of reset; SEED must not be 4'b1111
module lfsr4_xnor #(
    parameter logic [3:0] SEED = 4'b0001
) (
    input  logic       i_clk,
    input  logic       i_reset,
    output logic [3:0] o_lfsr
);

    logic [3:0] r_lfsr;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= {r_lfsr[2:0], ~(r_lfsr[3] ^ r_lfsr[2])};
        end
    end

    assign o_lfsr = r_lfsr;

endmodule

// File: rtl/cpu_attack_ctrl.sv
// rtl/cpu_attack_ctrl.sv - CPU opponent attack sequencer (wind-up, strike handshake, recovery); optional CPU_ATTACK_QUEUE_EN
module cpu_attack_ctrl
    import cpu_game_pkg::*;
#(
    parameter int         WINDUP_CYCLES  = 25_000_000,
    parameter int         RECOVER_CYCLES = 50_000_000,
    parameter logic [3:0] LFSR_SEED      = 4'b0001,
    parameter int         CNT_W          = 32
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_cpu_clk,
    input  logic       i_attack_ack,
    output logic       o_attack_valid,
    output logic [1:0] o_attack_type,
    output logic [1:0] o_damage,
    output logic       o_windup,
    output logic [1:0] o_state,
    output logic [7:0] o_drop_cnt
);

    localparam logic [CNT_W-1:0] WINDUP_LOAD  = CNT_W'(WINDUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] RECOVER_LOAD = CNT_W'(RECOVER_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    logic             r_cpu_clk_d;
    logic [3:0]       r_lfsr;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_type;
    logic             r_valid;
    logic [7:0]       r_drop_cnt;

    logic       rise;
    logic       busy;
    logic [1:0] drawn;
    logic       capture;
    logic       drop;
    logic       rec_exit;
    logic       launch_valid;
    logic [1:0] launch_type;
    logic       unused_lfsr_hi;

    lfsr4_xnor #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .o_lfsr  (r_lfsr)
    );

    assign unused_lfsr_hi = ^r_lfsr[3:2];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cpu_clk_d <= 1'b0;
        end else begin
            r_cpu_clk_d <= i_cpu_clk;
        end
    end

    assign rise     = i_cpu_clk & ~r_cpu_clk_d;
    assign busy     = (r_state != ST_IDLE);
    assign drawn    = draw_type(r_lfsr[1:0]);
    assign rec_exit = (r_state == ST_RECOVER) && (r_cnt == '0);

`ifdef CPU_ATTACK_QUEUE_EN
    logic       r_pend_valid;
    logic [1:0] r_pend_type;

    assign capture = busy && rise && !r_pend_valid && (drawn != STANDBY);

    // A capture on the last recovery cycle launches directly without touching the slot
    assign launch_valid = r_pend_valid || capture;
    assign launch_type  = r_pend_valid ? r_pend_type : drawn;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pend_valid <= 1'b0;
            r_pend_type  <= STANDBY;
        end else if (rec_exit) begin
            r_pend_valid <= 1'b0;
            r_pend_type  <= STANDBY;
        end else if (capture) begin
            r_pend_valid <= 1'b1;
            r_pend_type  <= drawn;
        end
    end
`else
    assign capture      = 1'b0;
    assign launch_valid = 1'b0;
    assign launch_type  = STANDBY;
`endif

    assign drop = busy && rise && !capture;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_type  <= STANDBY;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (rise && (drawn != STANDBY)) begin
                        r_type  <= drawn;
                        r_cnt   <= WINDUP_LOAD;
                        r_state <= ST_WINDUP;
                    end
                end
                ST_WINDUP: begin
                    if (r_cnt == '0) begin
                        r_valid <= 1'b1;
                        r_state <= ST_STRIKE;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                ST_STRIKE: begin
                    if (i_attack_ack) begin
                        r_valid <= 1'b0;
                        r_type  <= STANDBY;
                        r_cnt   <= RECOVER_LOAD;
                        r_state <= ST_RECOVER;
                    end
                end
                default: begin
                    if (rec_exit) begin
                        if (launch_valid) begin
                            r_type  <= launch_type;
                            r_cnt   <= WINDUP_LOAD;
                            r_state <= ST_WINDUP;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_drop_cnt <= 8'd0;
        end else if (drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign o_attack_valid = r_valid;
    assign o_attack_type  = r_type;
    assign o_damage       = damage_of(r_type);
    assign o_windup       = (r_state == ST_WINDUP);
    assign o_state        = r_state;
    assign o_drop_cnt     = r_drop_cnt;

endmodule

// File: tb/tb_cpu_attack_ctrl.sv
// tb/tb_cpu_attack_ctrl.sv - randomized scoreboard bench for cpu_attack_ctrl
module tb_cpu_attack_ctrl;

    localparam int         W    = 4;
    localparam int         R    = 3;
    localparam logic [3:0] SEED = 4'b0001;
`ifdef CPU_ATTACK_QUEUE_EN
    localparam bit QEN = 1'b1;
`else
    localparam bit QEN = 1'b0;
`endif

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic       i_cpu_clk;
    logic       i_attack_ack;
    logic       o_attack_valid;
    logic [1:0] o_attack_type;
    logic [1:0] o_damage;
    logic       o_windup;
    logic [1:0] o_state;
    logic [7:0] o_drop_cnt;

    cpu_attack_ctrl #(
        .WINDUP_CYCLES  (W),
        .RECOVER_CYCLES (R),
        .LFSR_SEED      (SEED),
        .CNT_W          (8)
    ) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_cpu_clk      (i_cpu_clk),
        .i_attack_ack   (i_attack_ack),
        .o_attack_valid (o_attack_valid),
        .o_attack_type  (o_attack_type),
        .o_damage       (o_damage),
        .o_windup       (o_windup),
        .o_state        (o_state),
        .o_drop_cnt     (o_drop_cnt)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Reference: mode 0 idle, 1 windup, 2 strike, 3 recover; m_left counts remaining cycles of a timed phase
    int         m_mode;
    int         m_left;
    int         m_drop;
    logic [1:0] m_type;
    logic [3:0] m_lfsr;
    bit         m_cpu_d;
    bit         m_pend;
    logic [1:0] m_pend_type;

    typedef struct {
        logic [1:0] typ;
        int         at;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;
    bit   mon_prev = 1'b0;

    function automatic logic [1:0] type_of(input logic [3:0] l);
        int v;
        v = int'(l) % 4;
        if (v == 0) return 2'd0;
        if (v == 3) return 2'd2;
        return 2'd1;
    endfunction

    function automatic logic [1:0] dmg_of(input logic [1:0] t);
        if (t == 2'd1) return 2'd1;
        if (t == 2'd2) return 2'd3;
        return 2'd0;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_left = 0; m_drop = 0; m_type = 2'd0;
        m_lfsr = SEED; m_cpu_d = 1'b0; m_pend = 1'b0; m_pend_type = 2'd0;
        sb.delete();
    endtask

    task automatic start_attack(input logic [1:0] t);
        exp_t e;
        m_mode = 1; m_left = W; m_type = t;
        e.typ = t; e.at = cyc + 1 + W;
        sb.push_back(e);
    endtask

    task automatic model_step(input bit cpu, input bit ack);
        bit         rise;
        logic [1:0] d;
        rise    = cpu && !m_cpu_d;
        m_cpu_d = cpu;
        d       = type_of(m_lfsr);
        m_lfsr  = {m_lfsr[2:0], ~(m_lfsr[3] ^ m_lfsr[2])};
        if (m_mode != 0 && rise) begin
            if (QEN && !m_pend && d != 2'd0) begin
                m_pend = 1'b1; m_pend_type = d;
            end else if (m_drop < 255) begin
                m_drop++;
            end
        end
        case (m_mode)
            0: if (rise && d != 2'd0) start_attack(d);
            1: begin m_left--; if (m_left == 0) m_mode = 2; end
            2: if (ack) begin m_mode = 3; m_left = R; m_type = 2'd0; end
            default: begin
                m_left--;
                if (m_left == 0) begin
                    if (m_pend) begin m_pend = 1'b0; start_attack(m_pend_type); end
                    else m_mode = 0;
                end
            end
        endcase
    endtask

    task automatic check_outputs(input string name);
        logic [15:0] got, exp;
        got = {o_attack_valid, o_attack_type, o_damage, o_windup, o_state, o_drop_cnt};
        exp = {m_mode == 2, m_type, dmg_of(m_type), m_mode == 1, 2'(m_mode), 8'(m_drop)};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
        end
    endtask

    task automatic check_val(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic step(input bit cpu, input bit ack);
        i_cpu_clk    = cpu;
        i_attack_ack = ack;
        model_step(cpu, ack);
        @(negedge i_clk);
        check_outputs("outputs");
    endtask

    task automatic wait_mode(input int target, input int budget);
        int n;
        n = budget;
        while (m_mode != target && n > 0) begin
            step(1'b0, 1'b0);
            n--;
        end
        if (m_mode != target) check_val("wait_mode_timeout", m_mode, target);
    endtask

    task automatic settle();
        int n;
        n = 200;
        while (m_mode != 0 && n > 0) begin
            step(1'b0, m_mode == 2);
            n--;
        end
        check_val("settle_idle", int'(o_state), 0);
    endtask

    task automatic do_reset();
        i_reset = 1'b1; i_cpu_clk = 1'b0; i_attack_ack = 1'b0;
        model_reset();
        @(negedge i_clk);
        check_outputs("reset_state");
        @(negedge i_clk);
        i_reset = 1'b0;
    endtask

    // Scoreboard monitor: each new strike must match the oldest predicted attack
    always @(negedge i_clk) begin
        if (i_reset) begin
            mon_prev = 1'b0;
        end else begin
            if (o_attack_valid && !mon_prev) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL strike_unexpected cyc=%0d type=%0d", cyc, o_attack_type);
                end else begin
                    mon_e = sb.pop_front();
                    if (o_attack_type !== mon_e.typ || o_damage !== dmg_of(mon_e.typ) || cyc != mon_e.at) begin
                        bad++;
                        $display("FAIL strike got type=%0d dmg=%0d cyc=%0d expected type=%0d dmg=%0d cyc=%0d",
                                 o_attack_type, o_damage, cyc, mon_e.typ, dmg_of(mon_e.typ), mon_e.at);
                    end
                end
            end
            mon_prev = o_attack_valid;
        end
    end

    initial begin
        do_reset();

        // First edge after reset draws LIGHT from the seed
        step(1'b1, 1'b0);
        wait_mode(2, 20);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        wait_mode(0, 20);

        // Second edge draws HEAVY; ack withheld for 10 strike cycles
        do_reset();
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        wait_mode(2, 20);
        check_val("heavy_damage", int'(o_damage), 3);
        repeat (10) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        wait_mode(0, 20);

        // Rises during WINDUP and RECOVER
        do_reset();
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        wait_mode(2, 20);
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        settle();
        check_val("busy_rises_dropped", int'(o_drop_cnt), QEN ? 1 : 2);

        // Drop counter saturation while stuck in STRIKE
        do_reset();
        step(1'b1, 1'b0);
        wait_mode(2, 20);
        repeat (300) begin
            step(1'b1, 1'b0);
            step(1'b0, 1'b0);
        end
        check_val("drop_saturate", int'(o_drop_cnt), 255);

        // Asynchronous reset mid-STRIKE clears outputs before the next edge
        #2 i_reset = 1'b1;
        #1;
        model_reset();
        check_outputs("async_reset");
        @(negedge i_clk);
        check_outputs("async_reset_hold");
        i_reset = 1'b0;
        step(1'b1, 1'b0);
        check_val("seed_draw_after_reset", int'(o_attack_type), 1);
        settle();

        // Rise on a STANDBY draw is consumed silently
        begin : standby_case
            int n;
            n = 20;
            while (!(m_mode == 0 && m_lfsr[1:0] == 2'b00) && n > 0) begin
                step(1'b0, 1'b0);
                n--;
            end
            check_val("standby_reached", int'(m_lfsr[1:0]), 0);
            step(1'b1, 1'b0);
            check_val("standby_state", int'(o_state), 0);
            check_val("standby_drop", int'(o_drop_cnt), m_drop);
        end

        // Randomized traffic
        do_reset();
        repeat (3000) begin
            step(($urandom % 4) == 0, (m_mode == 2) ? (($urandom % 3) == 0) : (($urandom % 8) == 0));
        end
        settle();
        @(negedge i_clk);
        check_val("scoreboard_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
